// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
package muldiv_pkg;

    // Operation encodings carried on the func port
    localparam logic [2:0] FUNC_MUL   = 3'b000;
    localparam logic [2:0] FUNC_UMUL  = 3'b001;
    localparam logic [2:0] FUNC_MULH  = 3'b010;
    localparam logic [2:0] FUNC_UMULH = 3'b011;
    localparam logic [2:0] FUNC_DIV   = 3'b100;
    localparam logic [2:0] FUNC_UDIV  = 3'b101;
    localparam logic [2:0] FUNC_REM   = 3'b110;
    localparam logic [2:0] FUNC_UREM  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Operands are two's complement for these functions
    function automatic logic is_signed(input logic [2:0] f);
        return (f == FUNC_MUL) || (f == FUNC_MULH) || (f == FUNC_DIV) || (f == FUNC_REM);
    endfunction

    // Division family (quotient or remainder)
    function automatic logic is_div(input logic [2:0] f);
        return (f == FUNC_DIV) || (f == FUNC_UDIV) || (f == FUNC_REM) || (f == FUNC_UREM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {acc,q} pair: shift-add multiply or restoring divide.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module muldiv_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shl;
    logic [WIDTH:0] w_diff;

    // Multiply: add multiplicand when multiplier LSB is set, then shift the pair right
    // (carry enters acc MSB). Divide: shift pair left, keep the trial subtraction when
    // it does not borrow and record a quotient 1.
    always_comb begin
        w_sum  = {1'b0, i_acc} + {1'b0, i_opnd};
        w_shl  = {i_acc, i_q[WIDTH-1]};
        w_diff = w_shl - {1'b0, i_opnd};
        o_acc  = i_acc;
        o_q    = i_q;
        if (i_div) begin
            if (!w_diff[WIDTH]) begin
                o_acc = w_diff[WIDTH-1:0];
                o_q   = {i_q[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = w_shl[WIDTH-1:0];
                o_q   = {i_q[WIDTH-2:0], 1'b0};
            end
        end else if (i_q[0]) begin
            {o_acc, o_q} = {w_sum, i_q[WIDTH-1:1]};
        end else begin
            {o_acc, o_q} = {1'b0, i_acc, i_q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/seq_muldiv_alu.sv
// Iterative signed/unsigned multiply, divide and remainder for the EX stage.
// Latency: accept to out_valid WIDTH+2 cycles; 2 cycles on zero multiplicand/divisor bypass.
// Backpressure: one op at a time; in_ready only in IDLE, result held in DONE until out_ready.
module seq_muldiv_alu
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter bit          ZERO_BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dst_EX_DM,
    output logic             ov,
    output logic             zr,
    output logic             neg,
    output logic             busy
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             r_state;
    state_t             w_state_nxt;

    logic [2:0]         r_func;
    logic [WIDTH-1:0]   r_src1;
    logic [WIDTH-1:0]   r_src0;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_sgn_q;   // product / quotient must be negated
    logic               r_sgn_r;   // remainder must be negated
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   r_dst;
    logic               r_ov;
    logic               r_zr;
    logic               r_neg;

    logic               w_accept;
    logic               w_signed;
    logic               w_div;
    logic               w_bypass;
    logic               w_dz;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs0;
    logic [WIDTH-1:0]   w_step_acc;
    logic [WIDTH-1:0]   w_step_q;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res;
    logic               w_res_ov;

    // A flush in IDLE also blocks acceptance of a concurrent request
    assign w_accept = in_valid && (r_state == ST_IDLE) && !flush;
    assign w_signed = is_signed(r_func);
    assign w_div    = is_div(r_func);
    assign w_abs1   = (w_signed && r_src1[WIDTH-1]) ? -r_src1 : r_src1;
    assign w_abs0   = (w_signed && r_src0[WIDTH-1]) ? -r_src0 : r_src0;
    assign w_dz     = w_div && (r_src0 == '0);
    assign w_bypass = ZERO_BYPASS && (w_div ? (r_src0 == '0) : (r_src1 == '0));

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_div  (w_div),
        .i_acc  (r_acc),
        .i_q    (r_q),
        .i_opnd (r_opnd),
        .o_acc  (w_step_acc),
        .o_q    (w_step_q)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: flush overrides everything, including a pending out_ready
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_PREP;
            ST_PREP: w_state_nxt = w_bypass ? ST_FIX : ST_CALC;
            ST_CALC: if (r_cnt == '0) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Fix-up: apply signs, pick the product half or quotient/remainder, and handle
    // divide-by-zero and signed overflow cases
    always_comb begin
        w_prod   = {r_acc, r_q};
        w_prod_s = r_sgn_q ? -w_prod : w_prod;
        w_quo    = r_sgn_q ? -r_q : r_q;
        w_rem    = r_sgn_r ? -r_acc : r_acc;
        w_res    = '0;
        w_res_ov = 1'b0;
        case (r_func)
            FUNC_MUL: begin
                w_res    = w_prod_s[WIDTH-1:0];
                w_res_ov = (w_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_s[WIDTH-1]}});
            end
            FUNC_UMUL: begin
                w_res    = w_prod_s[WIDTH-1:0];
                w_res_ov = (w_prod_s[2*WIDTH-1:WIDTH] != '0);
            end
            FUNC_MULH, FUNC_UMULH: begin
                w_res    = w_prod_s[2*WIDTH-1:WIDTH];
                w_res_ov = 1'b0;
            end
            FUNC_DIV, FUNC_UDIV: begin
                w_res    = w_dz ? '1 : w_quo;
                // MIN / -1 cannot be represented; the magnitude path already yields MIN
                w_res_ov = w_dz || ((r_func == FUNC_DIV) && (r_src1 == MIN_VAL) && (r_src0 == '1));
            end
            default: begin
                // FUNC_REM, FUNC_UREM
                w_res    = w_dz ? r_src1 : w_rem;
                w_res_ov = w_dz;
            end
        endcase
    end

    // Operand capture, datapath preparation, iteration and result registration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_func  <= '0;
            r_src1  <= '0;
            r_src0  <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_opnd  <= '0;
            r_sgn_q <= 1'b0;
            r_sgn_r <= 1'b0;
            r_cnt   <= '0;
            r_dst   <= '0;
            r_ov    <= 1'b0;
            r_zr    <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_func <= func;
                r_src1 <= src1;
                r_src0 <= src0;
            end
            case (r_state)
                ST_PREP: begin
                    r_acc   <= '0;
                    r_cnt   <= CNT_LAST;
                    r_sgn_q <= w_signed && (r_src1[WIDTH-1] ^ r_src0[WIDTH-1]);
                    r_sgn_r <= w_signed && r_src1[WIDTH-1];
                    if (w_div) begin
                        r_q    <= w_abs1;
                        r_opnd <= w_abs0;
                    end else begin
                        // Zero multiplicand gives a zero product; clearing q makes the
                        // bypass path read a correct {acc,q} without iterating
                        r_q    <= (r_src1 == '0) ? '0 : w_abs0;
                        r_opnd <= w_abs1;
                    end
                end
                ST_CALC: begin
                    r_acc <= w_step_acc;
                    r_q   <= w_step_q;
                    r_cnt <= r_cnt - 1'b1;
                end
                ST_FIX: begin
                    if (!flush) begin
                        r_dst <= w_res;
                        r_ov  <= w_res_ov;
                        r_zr  <= (w_res == '0);
                        r_neg <= w_signed && w_res[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign dst_EX_DM = r_dst;
    assign ov        = r_ov;
    assign zr        = r_zr;
    assign neg       = r_neg;

endmodule

// File: tb/tb_seq_muldiv_alu.sv
// Directed bench for seq_muldiv_alu at WIDTH=16 with zero bypass enabled.
// Expected results are hand-computed constants per vector.
// Covers reset, all functions, latency, hold under backpressure, flush and async reset.
module tb_seq_muldiv_alu;
    import muldiv_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   func;
    logic [W-1:0] src1;
    logic [W-1:0] src0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] dst_EX_DM;
    logic         ov;
    logic         zr;
    logic         neg;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_muldiv_alu #(
        .WIDTH       (W),
        .ZERO_BYPASS (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func      (func),
        .src1      (src1),
        .src0      (src0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dst_EX_DM (dst_EX_DM),
        .ov        (ov),
        .zr        (zr),
        .neg       (neg),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        func     = f;
        src1     = a;
        src0     = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] e_dst, input logic e_ov,
                          input logic e_zr, input logic e_neg, input int e_lat);
        int lat;
        issue(f, a, b);
        wait_valid(lat);
        check({tag, ".lat"}, lat, e_lat);
        check({tag, ".dst"}, {16'd0, dst_EX_DM}, {16'd0, e_dst});
        check({tag, ".ov"},  {31'd0, ov},  {31'd0, e_ov});
        check({tag, ".zr"},  {31'd0, zr},  {31'd0, e_zr});
        check({tag, ".neg"}, {31'd0, neg}, {31'd0, e_neg});
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        func      = '0;
        src1      = '0;
        src0      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready",  {31'd0, in_ready},  32'd1);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.dst",       {16'd0, dst_EX_DM}, 32'd0);
        check("rst.ov",        {31'd0, ov},        32'd0);
        check("rst.zr",        {31'd0, zr},        32'd0);
        check("rst.neg",       {31'd0, neg},       32'd0);
        check("rst.busy",      {31'd0, busy},      32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        //     tag          func        src1     src0     dst      ov    zr    neg   lat
        run_op("mul_neg",   FUNC_MUL,   16'h0003, 16'hFFFE, 16'hFFFA, 1'b0, 1'b0, 1'b1, 18);
        run_op("mul_ovf",   FUNC_MUL,   16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 18);
        run_op("umulh_max", FUNC_UMULH, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 1'b0, 18);
        run_op("div_min",   FUNC_DIV,   16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1, 18);
        run_op("udiv_z",    FUNC_UDIV,  16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 2);
        run_op("rem_neg",   FUNC_REM,   16'hFFF9, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 1'b1, 18);
        run_op("urem",      FUNC_UREM,  16'h0007, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b0, 18);
        run_op("umul_ovf",  FUNC_UMUL,  16'h1234, 16'h0010, 16'h2340, 1'b1, 1'b0, 1'b0, 18);
        run_op("mulh_neg",  FUNC_MULH,  16'hFFFE, 16'h0003, 16'hFFFF, 1'b0, 1'b0, 1'b1, 18);
        run_op("div_neg",   FUNC_DIV,   16'hFFF9, 16'h0002, 16'hFFFD, 1'b0, 1'b0, 1'b1, 18);
        run_op("rem_min",   FUNC_REM,   16'h8000, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 18);
        run_op("div_z",     FUNC_DIV,   16'h0064, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1, 2);
        run_op("rem_z",     FUNC_REM,   16'h0005, 16'h0000, 16'h0005, 1'b1, 1'b0, 1'b0, 2);
        run_op("mul_zbyp",  FUNC_MUL,   16'h0000, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, 2);
        run_op("mul_zmplr", FUNC_MUL,   16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 18);
        run_op("udiv",      FUNC_UDIV,  16'hFFFF, 16'h0010, 16'h0FFF, 1'b0, 1'b0, 1'b0, 18);
        run_op("rem_dvneg", FUNC_REM,   16'h0007, 16'hFFFE, 16'h0001, 1'b0, 1'b0, 1'b0, 18);
        run_op("div_dvneg", FUNC_DIV,   16'h0007, 16'hFFFE, 16'hFFFD, 1'b0, 1'b0, 1'b1, 18);
        run_op("mul_maxp",  FUNC_MUL,   16'h7FFF, 16'h0002, 16'hFFFE, 1'b1, 1'b0, 1'b1, 18);
        run_op("mul_m1m1",  FUNC_MUL,   16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 18);

        // Result held while the consumer stalls
        out_ready = 1'b0;
        issue(FUNC_MUL, 16'h0003, 16'hFFFE);
        wait_valid(lat);
        check("hold.lat", lat, 18);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold.out_valid", {31'd0, out_valid}, 32'd1);
            check("hold.in_ready",  {31'd0, in_ready},  32'd0);
            check("hold.dst",       {16'd0, dst_EX_DM}, 32'h0000FFFA);
            check("hold.neg",       {31'd0, neg},       32'd1);
            check("hold.ov",        {31'd0, ov},        32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold.release_valid", {31'd0, out_valid}, 32'd0);
        check("hold.release_ready", {31'd0, in_ready},  32'd1);

        // Flush while idle blocks a concurrent request
        flush    = 1'b1;
        in_valid = 1'b1;
        func     = FUNC_UDIV;
        src1     = 16'h0010;
        src0     = 16'h0002;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_idle.busy",     {31'd0, busy},     32'd0);
        check("flush_idle.in_ready", {31'd0, in_ready}, 32'd1);

        // Flush in the 5th CALC cycle aborts without a result
        issue(FUNC_DIV, 16'h0064, 16'h0007);
        repeat (5) @(posedge clk);
        #1;
        check("flush.busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush.in_ready",  {31'd0, in_ready},  32'd1);
        check("flush.busy",      {31'd0, busy},      32'd0);
        check("flush.out_valid", {31'd0, out_valid}, 32'd0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush.no_result", seen, 0);
        check("flush.dst_kept",  {16'd0, dst_EX_DM}, 32'h0000FFFA);

        // Asynchronous reset mid-CALC
        issue(FUNC_MUL, 16'h0003, 16'h0005);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid.dst",       {16'd0, dst_EX_DM}, 32'd0);
        check("rst_mid.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid.in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_mid.busy",      {31'd0, busy},      32'd0);
        check("rst_mid.neg",       {31'd0, neg},       32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("after_rst", FUNC_UREM, 16'h0007, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b0, 18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
